// File: rtl/note_scroller.sv
// Rhythm-game note highway: per-lane shift window fed from song RAM.
// Column 0 is the judgment column; tick scrolls toward it.
module note_scroller #(
  parameter int LANES    = 3,
  parameter int SONG_LEN = 100,
  parameter int WINDOW   = 10,
  localparam int AW = $clog2(SONG_LEN),
  localparam int PW = $clog2(SONG_LEN+WINDOW+1)
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      tick,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      pause,
  input  logic                      loop_en,
  input  logic                      wr_en,
  input  logic [AW-1:0]             wr_addr,
  input  logic [LANES-1:0]          wr_data,
  input  logic [LANES-1:0]          hit_clear,
  output logic [LANES*WINDOW-1:0]   window_out,
  output logic [LANES-1:0]          judge_notes,
  output logic [PW-1:0]             position,
  output logic                      busy,
  output logic                      done
);

  localparam int RW = $clog2(SONG_LEN+WINDOW);
  localparam int NB = LANES*WINDOW;

  localparam logic [RW-1:0] PTR_WRAP = RW'(SONG_LEN-1);
  localparam logic [RW-1:0] PTR_END  = RW'(SONG_LEN);
  localparam logic [RW-1:0] PTR_LAST = RW'(SONG_LEN+WINDOW-1);
  localparam logic [PW-1:0] POS_MAX  = PW'(SONG_LEN+WINDOW);
  localparam logic [AW:0]   ADR_END  = (AW+1)'(SONG_LEN);

  typedef enum logic [1:0] {
    IDLE, PLAY, PAUSED, DONE
  } state_t;

  state_t           state;
  logic [LANES-1:0] song [SONG_LEN];
  logic [NB-1:0]    win;
  logic [NB-1:0]    win_shift;
  logic [NB-1:0]    win_hit;
  logic [RW-1:0]    rd_ptr;
  logic [LANES-1:0] fill;
  logic             idle_like;
  logic             run;
  logic             do_start;
  logic             accept;
  logic             hold;

  assign idle_like = (state == IDLE) || (state == DONE);
  assign run       = (state == PLAY) || (state == PAUSED);
  assign do_start  = !stop && idle_like && start;
  assign accept    = !stop && (state == PLAY) && tick && !pause;
  assign hold      = !stop && run && !accept;

  assign window_out = win;
  assign busy       = run;

  // Song RAM is deliberately outside the reset domain
  always_ff @(posedge clock)
    if (wr_en && idle_like && ({1'b0, wr_addr} < ADR_END))
      song[wr_addr] <= wr_data;

  always_comb begin
    fill = '0;
    if (rd_ptr < PTR_END)
      fill = song[rd_ptr[AW-1:0]];
  end

  always_comb begin
    win_shift   = '0;
    win_hit     = win;
    judge_notes = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int c = 0; c < WINDOW-1; c++)
        win_shift[l*WINDOW+c] = win[l*WINDOW+c+1];
      win_shift[l*WINDOW+WINDOW-1] = fill[l];
      if (hit_clear[l])
        win_hit[l*WINDOW] = 1'b0;
      judge_notes[l] = win[l*WINDOW];
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      win      <= '0;
      rd_ptr   <= '0;
      position <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (1'b1)
        stop: begin
          state <= IDLE;
          win   <= '0;
        end
        do_start: begin
          state    <= PLAY;
          win      <= '0;
          rd_ptr   <= '0;
          position <= '0;
        end
        accept: begin
          win <= win_shift;
          if (position != POS_MAX)
            position <= position + 1'b1;
          // rd_ptr runs past the song end to drain the window
          if (loop_en && rd_ptr >= PTR_WRAP)
            rd_ptr <= '0;
          else if (!loop_en && rd_ptr == PTR_LAST) begin
            state <= DONE;
            done  <= 1'b1;
            win   <= '0;
          end else
            rd_ptr <= rd_ptr + 1'b1;
        end
        hold: begin
          win <= win_hit;
          if (state == PLAY && pause)
            state <= PAUSED;
          else if (state == PAUSED && !pause)
            state <= PLAY;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/note_scroller.md
NOTE_SCROLLER -- requirements
Module: note_scroller

Interface
REQ-001 Parameter LANES, default 3, number of note lanes (one per player key).
REQ-002 Parameter SONG_LEN, default 100, song length in columns (one column = one tick).
REQ-003 Parameter WINDOW, default 10, visible columns per lane; column 0 is the judgment column.
REQ-004 Derived: AW = $clog2(SONG_LEN); PW = $clog2(SONG_LEN+WINDOW+1).
REQ-005 clock  in  1  sole clock; all state changes on rising edge.
REQ-006 resetn  in  1  asynchronous, active-low reset.
REQ-007 tick  in  1  one-cycle scroll enable from the rate divider.
REQ-008 start  in  1  begin playback from song column 0.
REQ-009 stop  in  1  abort playback, return to IDLE.
REQ-010 pause  in  1  level; while high in PLAY, ticks are ignored.
REQ-011 loop_en  in  1  level; wrap the song instead of finishing.
REQ-012 wr_en  in  1  song memory write strobe.
REQ-013 wr_addr  in  AW  song column to write.
REQ-014 wr_data  in  LANES  note bits for that column, bit l = lane l.
REQ-015 hit_clear  in  LANES  clear judgment-column note in lane l (note consumed by player).
REQ-016 window_out  out  LANES*WINDOW  bit l*WINDOW+c = note in lane l, column c.
REQ-017 judge_notes  out  LANES  column 0 of each lane.
REQ-018 position  out  PW  ticks accepted since start.
REQ-019 busy  out  1  high in PLAY or PAUSED.
REQ-020 done  out  1  one-cycle pulse on the cycle the song finishes.

Function
REQ-021 States: IDLE, PLAY, PAUSED, DONE; encoding free.
REQ-022 IDLE/DONE + start -> PLAY; window cleared, read pointer and position set to 0 on that edge.
REQ-023 PLAY + pause=1 -> PAUSED; PAUSED + pause=0 -> PLAY; no window/pointer/position change while PAUSED.
REQ-024 stop=1 from any state -> IDLE next edge, window cleared; stop wins over start, pause, tick.
REQ-025 Accepted tick (PLAY, pause=0, stop=0): every lane shifts one column toward column 0, column 0 discarded, column WINDOW-1 loaded with song[rd_ptr] (zeros once rd_ptr = SONG_LEN and loop_en=0); rd_ptr and position increment.
REQ-026 Song column i is in column 0 after accepted tick i+WINDOW (1-based tick count).
REQ-027 loop_en=1: rd_ptr wraps SONG_LEN-1 -> 0 with no gap column; position saturates at max; DONE never entered.
REQ-028 loop_en=0: on accepted tick number SONG_LEN+WINDOW the window becomes all-zero, state -> DONE, done pulses high for exactly that one following cycle.
REQ-029 loop_en sampled on every tick; clearing it mid-song lets the current pass finish normally.
REQ-030 hit_clear[l] in PLAY or PAUSED zeroes window bit l*WINDOW+0 at the next edge; ignored in IDLE/DONE.
REQ-031 hit_clear coincident with an accepted tick: shift takes effect, clear has no further effect (new column 0 content from column 1 kept).
REQ-032 Song writes accepted only in IDLE or DONE; ignored in PLAY/PAUSED; wr_addr >= SONG_LEN ignored.
REQ-033 Write and start on the same edge: write lands, start proceeds; a write to column 0 is visible to the first tick.
REQ-034 tick in IDLE, DONE or PAUSED has no effect; tick is a pulse, a held-high tick scrolls once per cycle.
REQ-035 window_out, judge_notes, position, busy, done are registered or pure decode of registers; no combinational path from inputs.

Reset
REQ-036 resetn low: state IDLE, window_out 0, judge_notes 0, position 0, rd_ptr 0, busy 0, done 0, immediately, regardless of clock.
REQ-037 Song memory contents are not affected by resetn; reset mid-playback leaves the loaded song intact for the next start.
REQ-038 Deassertion of resetn is synchronised externally; first edge after release behaves as IDLE.

Verification
REQ-039 Defaults; write song[c] = 3'b001 for even c, 0 otherwise; start, 10 ticks -> judge_notes=001, position=10; 11th tick -> 000.
REQ-040 Same song, loop_en=0, 110 ticks -> done pulses once, state DONE, window_out=0, busy=0; tick 111 -> no change.
REQ-041 loop_en=1, 120 ticks -> no done; column 0 after tick 110 equals song[100 mod 100]=001; position saturated.
REQ-042 pause high for 5 cycles with 5 ticks offered mid-song -> window_out and position unchanged; release, 1 tick -> exactly one shift.
REQ-043 Lane 2 note at column 0, hit_clear=100 without tick -> judge_notes[2]=0 next cycle; repeat with tick coincident -> column 1 contents appear at column 0.
REQ-044 resetn pulsed low at position 57 -> all outputs 0 asynchronously; start again -> playback reproduces song from column 0 without rewrite.
